i2c_pcf8574_slave: RTL and testbench

I2C target (responder) that emulates a PCF8574 8-bit I/O expander at 7-bit address 0x27, the same device our CLCD write path drives.
- Receives address and data bytes on SCL/SDA, ACKs its own address, and presents each written byte on a parallel port with a strobe.
- Returns `i_port` for read transactions.
- Sits at the far end of the I2C bus, either in-fabric as a loopback/debug target for the I2C master or as the LCD-side decoder that feeds a parallel HD44780 driver.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_line_sync.sv | 36 +++
 rtl/i2c_pcf8574_slave.sv | 178 +++++++++++++++++
 tb/tb_i2c_pcf8574_slave.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Constants shared by the I2C master and target: FSM state codes, default
// target address, R/W bit position and ACK/NACK line levels.
package i2c_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_WR       = 3'd3;
  localparam logic [2:0] ST_WR_ACK   = 3'd4;
  localparam logic [2:0] ST_RD       = 3'd5;
  localparam logic [2:0] ST_RD_ACK   = 3'd6;
  localparam logic [2:0] ST_IGNORE   = 3'd7;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h27;
  localparam int         I2C_RW_BIT       = 0;
  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Multi-stage synchronizer for one bus line plus a history flop that yields
// single-clk rise/fall strobes. All flops reset to the idle-bus level (1).
module i2c_line_sync #(
  parameter int P_SYNC = 2
) (
  input  logic clk,
  input  logic reset_p,
  input  logic i_line,
  output logic o_line,
  output logic o_rise,
  output logic o_fall
);

  logic [P_SYNC-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[P_SYNC-2:0], i_line};
    hist_d = sync_q[P_SYNC-1];
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign o_line = sync_q[P_SYNC-1];
  assign o_rise = sync_q[P_SYNC-1] & ~hist_q;
  assign o_fall = ~sync_q[P_SYNC-1] & hist_q;

endmodule

// File: rtl/i2c_pcf8574_slave.sv
// I2C target emulating a PCF8574 I/O expander: written bytes appear on o_port
// with a one-clk strobe, reads return i_port. No clock stretching.
module i2c_pcf8574_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] P_ADDR = I2C_DEFAULT_ADDR,
  parameter int         P_SYNC = 2
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic [7:0] o_port,
  output logic       o_port_valid,
  input  logic [7:0] i_port,
  output logic       o_busy
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_line_sync #(.P_SYNC(P_SYNC)) u_scl_sync (
    .clk(clk), .reset_p(reset_p), .i_line(i_scl),
    .o_line(scl_s), .o_rise(scl_rise), .o_fall(scl_fall)
  );

  i2c_line_sync #(.P_SYNC(P_SYNC)) u_sda_sync (
    .clk(clk), .reset_p(reset_p), .i_line(i_sda),
    .o_line(sda_s), .o_rise(sda_rise), .o_fall(sda_fall)
  );

  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       bit_seen_q, bit_seen_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] port_q, port_d;
  logic       port_valid_q, port_valid_d;
  logic       busy_q, busy_d;

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    bit_seen_d   = bit_seen_q;
    rw_d         = rw_q;
    sda_oe_d     = sda_oe_q;
    port_d       = port_q;
    port_valid_d = 1'b0;
    busy_d       = busy_q;

    if (start_det) begin
      state_d    = ST_ADDR;
      bit_cnt_d  = 3'd0;
      bit_seen_d = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
    end else if (stop_det) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      bit_seen_d = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        // The SCL fall that follows START precedes any data bit, so a fall
        // only counts once a rise has shifted a bit in.
        ST_ADDR, ST_WR: begin
          if (scl_rise) begin
            shift_d    = {shift_q[6:0], sda_s};
            bit_seen_d = 1'b1;
          end else if (scl_fall && bit_seen_q) begin
            bit_seen_d = 1'b0;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_WR) begin
                port_d       = shift_q;
                port_valid_d = 1'b1;
                sda_oe_d     = 1'b1;
                state_d      = ST_WR_ACK;
              end else if (shift_q[7:1] == P_ADDR) begin
                rw_d     = shift_q[I2C_RW_BIT];
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                state_d  = ST_ADDR_ACK;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd0;
            if (rw_q) begin
              shift_d  = i_port;
              sda_oe_d = ~i_port[7];
              state_d  = ST_RD;
            end else begin
              sda_oe_d   = 1'b0;
              bit_seen_d = 1'b0;
              state_d    = ST_WR;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d   = 1'b0;
            bit_seen_d = 1'b0;
            state_d    = ST_WR;
          end
        end
        ST_RD: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        // A NACK ends the read at its rise; any later fall here follows an ACK.
        ST_RD_ACK: begin
          if (scl_rise && sda_s == I2C_NACK) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = ST_IGNORE;
          end else if (scl_fall) begin
            bit_cnt_d = 3'd0;
            shift_d   = i_port;
            sda_oe_d  = ~i_port[7];
            state_d   = ST_RD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      bit_seen_q   <= 1'b0;
      rw_q         <= 1'b0;
      sda_oe_q     <= 1'b0;
      port_q       <= 8'hFF;
      port_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      bit_seen_q   <= bit_seen_d;
      rw_q         <= rw_d;
      sda_oe_q     <= sda_oe_d;
      port_q       <= port_d;
      port_valid_q <= port_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign o_sda_oe     = sda_oe_q;
  assign o_port       = port_q;
  assign o_port_valid = port_valid_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_i2c_pcf8574_slave.sv
// Directed bench: a bit-banged I2C master on an open-drain SDA model drives
// the PCF8574 target through write, read, mismatch, abort and reset cases.
`timescale 1ns/1ps
module tb_i2c_pcf8574_slave;

  localparam int Q = 20;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] port_in = 8'h00;
  logic       o_sda_oe;
  logic [7:0] o_port;
  logic       o_port_valid;
  logic       o_busy;
  logic       sda_line;

  assign sda_line = sda_m & ~o_sda_oe;

  i2c_pcf8574_slave dut (
    .clk(clk), .reset_p(reset_p), .i_scl(scl_m), .i_sda(sda_line),
    .o_sda_oe(o_sda_oe), .o_port(o_port), .o_port_valid(o_port_valid),
    .i_port(port_in), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         valid_cnt = 0;
  logic [7:0] vals[$];
  logic       busy_seen = 1'b0;

  always @(negedge clk) begin
    if (o_port_valid) begin
      valid_cnt++;
      vals.push_back(o_port);
    end
    if (o_busy) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    wq(); sda_m = b; wq(); scl_m = 1'b1; wq(); wq(); scl_m = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); b = sda_line; wq(); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    for (int i = 7; i >= 0; i--) bit_in(d[i]);
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq();
    end
    sda_m = 1'b0; wq(); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(); sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         base;
    int         n;

    // Reset with idle bus
    repeat (4) @(negedge clk);
    chk("rst_port", o_port, 8'hFF);
    chk("rst_oe", o_sda_oe, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_valid", o_port_valid, 1'b0);
    reset_p = 1'b0;
    repeat (10) @(negedge clk);
    $display("txn reset: port=%0h oe=%0b busy=%0b", o_port, o_sda_oe, o_busy);

    // Single write 0x4E, 0xD9
    base = valid_cnt;
    i2c_start();
    write_byte(8'h4E, ack); chk("wr1_addr_ack", ack, 1'b0);
    write_byte(8'hD9, ack); chk("wr1_data_ack", ack, 1'b0);
    chk("wr1_busy_before_stop", o_busy, 1'b1);
    wq(); sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1;
    repeat (2) @(negedge clk);
    chk("wr1_busy_at_detect", o_busy, 1'b1);
    @(negedge clk);
    chk("wr1_busy_after_stop", o_busy, 1'b0);
    wq();
    chk("wr1_port", o_port, 8'hD9);
    chk("wr1_valid_cnt", valid_cnt - base, 1);
    chk("wr1_oe_idle", o_sda_oe, 1'b0);
    $display("txn single write: port=%0h pulses=%0d", o_port, valid_cnt - base);

    // Address mismatch 0x40, 0x12
    base = valid_cnt;
    busy_seen = 1'b0;
    i2c_start();
    write_byte(8'h40, ack); chk("mis_addr_nack", ack, 1'b1);
    write_byte(8'h12, ack); chk("mis_data_nack", ack, 1'b1);
    i2c_stop();
    chk("mis_port", o_port, 8'hD9);
    chk("mis_valid_cnt", valid_cnt - base, 0);
    chk("mis_busy_seen", busy_seen, 1'b0);
    $display("txn mismatch: port=%0h busy_seen=%0b", o_port, busy_seen);

    // Read of i_port with master NACK
    port_in = 8'hA5;
    i2c_start();
    write_byte(8'h4F, ack); chk("rd_addr_ack", ack, 1'b0);
    chk("rd_busy", o_busy, 1'b1);
    read_byte(d);
    chk("rd_data", d, 8'hA5);
    wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq();
    chk("rd_nack_oe", o_sda_oe, 1'b0);
    chk("rd_nack_busy", o_busy, 1'b0);
    wq(); scl_m = 1'b0;
    i2c_stop();
    chk("rd_end_oe", o_sda_oe, 1'b0);
    $display("txn read: data=%0h", d);

    // Multi-byte write with repeated START
    base = valid_cnt;
    vals.delete();
    port_in = 8'h5A;
    i2c_start();
    write_byte(8'h4E, ack); chk("mb_addr1_ack", ack, 1'b0);
    write_byte(8'h3C, ack); chk("mb_d0_ack", ack, 1'b0);
    write_byte(8'h38, ack); chk("mb_d1_ack", ack, 1'b0);
    i2c_start();
    write_byte(8'h4E, ack); chk("mb_addr2_ack", ack, 1'b0);
    write_byte(8'h0C, ack); chk("mb_d2_ack", ack, 1'b0);
    i2c_stop();
    n = valid_cnt - base;
    chk("mb_valid_cnt", n, 3);
    if (n == 3) begin
      chk("mb_val0", vals[0], 8'h3C);
      chk("mb_val1", vals[1], 8'h38);
      chk("mb_val2", vals[2], 8'h0C);
    end
    chk("mb_port", o_port, 8'h0C);
    $display("txn multi write: pulses=%0d port=%0h", n, o_port);

    // STOP after 4 bits of a data byte
    base = valid_cnt;
    i2c_start();
    write_byte(8'h4E, ack); chk("ab_addr_ack", ack, 1'b0);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
    i2c_stop();
    chk("ab_port", o_port, 8'h0C);
    chk("ab_valid_cnt", valid_cnt - base, 0);
    chk("ab_busy", o_busy, 1'b0);
    $display("txn abort: port=%0h", o_port);

    // Reset while the target is ACKing its address
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_out(d[0] ^ d[0] ^ ((8'h4E >> i) & 8'h01) != 0);
    n = 0;
    while (!o_sda_oe && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_ack_drive", o_sda_oe, 1'b1);
    #3 reset_p = 1'b1;
    #1 chk("rst_ack_oe", o_sda_oe, 1'b0);
    chk("rst_ack_port", o_port, 8'hFF);
    chk("rst_ack_busy", o_busy, 1'b0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
    reset_p = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_ack_after_oe", o_sda_oe, 1'b0);
    $display("txn reset during ack: oe=%0b port=%0h", o_sda_oe, o_port);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
